// File: rtl/regfile_wb.sv
// 32 x 32-bit register file, two combinational read ports, one writeback port.
// Define RF_TRACE_EN to add the commit-trace ports (trace_we/wR/wD/cnt).
module regfile_wb #(
   parameter int BYPASS = 1
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic [4:0]  rR1,
   input  logic [4:0]  rR2,
   output logic [31:0] rD1,
   output logic [31:0] rD2,
   input  logic [4:0]  wR,
   input  logic        rf_we,
   input  logic [31:0] wD
`ifdef RF_TRACE_EN
   ,
   output logic        trace_we,
   output logic [4:0]  trace_wR,
   output logic [31:0] trace_wD,
   output logic [31:0] trace_cnt
`endif
);

   localparam bit BYP_EN = (BYPASS != 0);

   logic [31:0] regs [32];
   logic        commit;

   // A write lands only when enabled, not aimed at x0 and not overridden by reset.
   assign commit = rf_we && (wR != 5'd0) && !cpu_rst;

   // NOTE: the storage is reset explicitly because every register must read zero
   // after reset; this keeps it in flops rather than an inferred RAM macro.
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         for (int i = 0; i < 32; i++) begin
            // NOTE: sequential state uses non-blocking assignments only.
            regs[i] <= '0;
         end
      end else if (commit) begin
         regs[wR] <= wD;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rD1 = regs[rR1];
      if (rR1 == 5'd0)
         rD1 = '0;
      else if (BYP_EN && commit && (wR == rR1))
         rD1 = wD;
   end

   always_comb begin
      rD2 = regs[rR2];
      if (rR2 == 5'd0)
         rD2 = '0;
      else if (BYP_EN && commit && (wR == rR2))
         rD2 = wD;
   end

`ifdef RF_TRACE_EN
   always_ff @(posedge cpu_clk) begin
      if (cpu_rst) begin
         trace_we  <= 1'b0;
         trace_wR  <= '0;
         trace_wD  <= '0;
         trace_cnt <= '0;
      end else begin
         trace_we <= commit;
         if (commit) begin
            trace_wR  <= wR;
            trace_wD  <= wD;
            trace_cnt <= trace_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb; runs a BYPASS=1 and a BYPASS=0
// instance side by side on identical stimulus. Trace checks need RF_TRACE_EN.
module tb_regfile_wb;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst;
   logic [4:0]  rR1, rR2, wR;
   logic        rf_we;
   logic [31:0] wD;
   logic [31:0] b1_rD1, b1_rD2, b0_rD1, b0_rD2;

   int n_vec = 0;
   int n_err = 0;

`ifdef RF_TRACE_EN
   logic        b1_twe, b0_twe;
   logic [4:0]  b1_twr, b0_twr;
   logic [31:0] b1_twd, b0_twd, b1_tcnt, b0_tcnt;
`endif

   regfile_wb #(.BYPASS(1)) dut_b1 (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .rR1     (rR1),
      .rR2     (rR2),
      .rD1     (b1_rD1),
      .rD2     (b1_rD2),
      .wR      (wR),
      .rf_we   (rf_we),
      .wD      (wD)
`ifdef RF_TRACE_EN
      ,
      .trace_we  (b1_twe),
      .trace_wR  (b1_twr),
      .trace_wD  (b1_twd),
      .trace_cnt (b1_tcnt)
`endif
   );

   regfile_wb #(.BYPASS(0)) dut_b0 (
      .cpu_clk (cpu_clk),
      .cpu_rst (cpu_rst),
      .rR1     (rR1),
      .rR2     (rR2),
      .rD1     (b0_rD1),
      .rD2     (b0_rD2),
      .wR      (wR),
      .rf_we   (rf_we),
      .wD      (wD)
`ifdef RF_TRACE_EN
      ,
      .trace_we  (b0_twe),
      .trace_wR  (b0_twr),
      .trace_wD  (b0_twd),
      .trace_cnt (b0_tcnt)
`endif
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
   task automatic tick();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      cpu_rst = 1'b1;
      rf_we   = 1'b0;
      wR      = '0;
      wD      = '0;
      rR1     = '0;
      rR2     = '0;
      tick();
      tick();
      cpu_rst = 1'b0;

      // Every index on both ports reads zero after reset.
      for (int i = 0; i < 32; i++) begin
         rR1 = 5'(i);
         rR2 = 5'(31 - i);
         settle();
         check($sformatf("rst_b1_rD1_x%0d", i), b1_rD1, 32'h0);
         check($sformatf("rst_b1_rD2_x%0d", 31 - i), b1_rD2, 32'h0);
         check($sformatf("rst_b0_rD1_x%0d", i), b0_rD1, 32'h0);
         check($sformatf("rst_b0_rD2_x%0d", 31 - i), b0_rD2, 32'h0);
      end
`ifdef RF_TRACE_EN
      check("rst_trace_we", {31'h0, b1_twe}, 32'h0);
      check("rst_trace_wR", {27'h0, b1_twr}, 32'h0);
      check("rst_trace_wD", b1_twd, 32'h0);
      check("rst_trace_cnt", b1_tcnt, 32'h0);
`endif

      // Write x5 with a same-cycle read on port 1: forwarded only with bypass.
      rf_we = 1'b1; wR = 5'd5; wD = 32'hDEADBEEF; rR1 = 5'd5; rR2 = 5'd0;
      settle();
      check("wr5_byp_b1", b1_rD1, 32'hDEADBEEF);
      check("wr5_byp_b0", b0_rD1, 32'h0);
      check("wr5_rd2_x0", b1_rD2, 32'h0);
      tick();
      rf_we = 1'b0; rR1 = 5'd5; rR2 = 5'd5;
      settle();
      check("x5_b1_rD1", b1_rD1, 32'hDEADBEEF);
      check("x5_b1_rD2", b1_rD2, 32'hDEADBEEF);
      check("x5_b0_rD1", b0_rD1, 32'hDEADBEEF);
      check("x5_b0_rD2", b0_rD2, 32'hDEADBEEF);
`ifdef RF_TRACE_EN
      check("tr5_we", {31'h0, b1_twe}, 32'h1);
      check("tr5_wR", {27'h0, b1_twr}, 32'd5);
      check("tr5_wD", b1_twd, 32'hDEADBEEF);
      check("tr5_cnt", b1_tcnt, 32'd1);
`endif

      // Disabled write with live wR/wD must not touch storage or bypass.
      wR = 5'd5; wD = 32'hCAFEF00D;
      settle();
      check("we0_nobyp", b1_rD1, 32'hDEADBEEF);
      tick();
      settle();
      check("we0_hold_b1", b1_rD1, 32'hDEADBEEF);
      check("we0_hold_b0", b0_rD2, 32'hDEADBEEF);
`ifdef RF_TRACE_EN
      check("we0_trace_we", {31'h0, b1_twe}, 32'h0);
      check("we0_trace_cnt", b1_tcnt, 32'd1);
`endif

      // Write to x0 is dropped and never forwarded.
      rf_we = 1'b1; wR = 5'd0; wD = 32'h12345678; rR1 = 5'd0;
      settle();
      check("x0_wr_cyc_b1", b1_rD1, 32'h0);
      check("x0_wr_cyc_b0", b0_rD1, 32'h0);
      tick();
      rf_we = 1'b0;
      settle();
      check("x0_after_b1", b1_rD1, 32'h0);
      check("x0_after_b0", b0_rD1, 32'h0);
`ifdef RF_TRACE_EN
      check("x0_trace_we", {31'h0, b1_twe}, 32'h0);
      check("x0_trace_cnt", b1_tcnt, 32'd1);
`endif

      // x7 = 1, then overwrite with same-cycle read on port 2.
      rf_we = 1'b1; wR = 5'd7; wD = 32'h1;
      tick();
      wD = 32'hA5A5A5A5; rR2 = 5'd7; rR1 = 5'd5;
      settle();
      check("x7_byp_b1", b1_rD2, 32'hA5A5A5A5);
      check("x7_byp_b0", b0_rD2, 32'h1);
      check("x7_p1_indep", b1_rD1, 32'hDEADBEEF);
      tick();
      rf_we = 1'b0;
      settle();
      check("x7_new_b1", b1_rD2, 32'hA5A5A5A5);
      check("x7_new_b0", b0_rD2, 32'hA5A5A5A5);
      check("x5_still_b0", b0_rD1, 32'hDEADBEEF);
`ifdef RF_TRACE_EN
      check("tr7_cnt", b1_tcnt, 32'd3);
      check("tr7_wD", b1_twd, 32'hA5A5A5A5);
`endif

      // Reset coincident with a write to x3: write dropped, bypass suppressed.
      cpu_rst = 1'b1; rf_we = 1'b1; wR = 5'd3; wD = 32'hFF; rR1 = 5'd3; rR2 = 5'd5;
      settle();
      check("rstwr_byp_b1", b1_rD1, 32'h0);
      check("rstwr_stored_b1", b1_rD2, 32'hDEADBEEF);
      tick();
      cpu_rst = 1'b0; rf_we = 1'b0; rR2 = 5'd7;
      settle();
      check("rstwr_x3_b1", b1_rD1, 32'h0);
      check("rstwr_x3_b0", b0_rD1, 32'h0);
      check("rstwr_x7_b1", b1_rD2, 32'h0);
`ifdef RF_TRACE_EN
      check("rstwr_trace_we", {31'h0, b1_twe}, 32'h0);
      check("rstwr_trace_cnt", b1_tcnt, 32'h0);

      // Counter wrap: preload all-ones, then commit x9.
      force dut_b1.trace_cnt = 32'hFFFFFFFF;
      #1;
      release dut_b1.trace_cnt;
      rf_we = 1'b1; wR = 5'd9; wD = 32'h55;
      tick();
      rf_we = 1'b0;
      settle();
      check("wrap_trace_we", {31'h0, b1_twe}, 32'h1);
      check("wrap_trace_wR", {27'h0, b1_twr}, 32'd9);
      check("wrap_trace_wD", b1_twd, 32'h55);
      check("wrap_trace_cnt", b1_tcnt, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
